instr_encoder: RTL

Streams operation requests into 32-bit MIPS instruction words and writes them sequentially into instruction memory. It is the encoding counterpart of the control decoder: every instruction the decoder recognises can be produced here. It sits between a bench or boot-loader source and the IM write port, and is used to load programs before the single-cycle core runs. A small FIFO decouples request acceptance from IM write back-pressure.

---
 rtl/instr_pkg.sv | 54 +++++
 rtl/instr_encoder_sync_fifo.sv | 64 ++++++
 rtl/instr_encoder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// ============================================================================
// Module      : instr_pkg
// Description : Shared definitions for the MIPS instruction encoder and the
//               control decoder: request operation codes, opcode and funct
//               constants, and the encoder load-state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_pkg;

  // Operation codes carried on req_op; 12..15 are illegal.
  typedef enum logic [3:0] {
    OP_ADDU = 4'd0,
    OP_SUBU = 4'd1,
    OP_SLT  = 4'd2,
    OP_JR   = 4'd3,
    OP_ORI  = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_LUI  = 4'd7,
    OP_LH   = 4'd8,
    OP_BEQ  = 4'd9,
    OP_JAL  = 4'd10,
    OP_NOP  = 4'd11
  } op_e;

  // Primary opcodes.
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LH    = 6'h21;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type funct codes.
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_JR   = 6'h08;

  // Encoder load states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/instr_encoder_sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with show-ahead output. Read data is the
//               head entry while non-empty and zero while empty.
// Ports       : clk, rst (async, active-high)
//               i_push/i_wdata : write side, ignored when full
//               i_pop          : read side, ignored when empty
//               o_rdata        : head entry (show-ahead)
//               o_full, o_empty, o_count : occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  // Gated so the output reads zero after reset rather than stale storage.
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : Encodes a stream of operation requests into 32-bit MIPS
//               instruction words and writes them to consecutive IM byte
//               addresses starting at BASE_ADDR after each start pulse.
// Ports       : clk, reset (async, active-high), start
//               req_*        : request handshake and fields
//               im_we/im_ready/im_addr/im_wdata : IM write port
//               busy, done, err : status
// Config      : ENC_JAL_JR_EN - when defined, jr and jal are encoded;
//               otherwise they are treated as illegal operations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
  import instr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [15:0] req_imm,
  input  logic [25:0] req_target,
  input  logic        req_last,
  output logic        im_we,
  input  logic        im_ready,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e         r_state;
  state_e         w_state_next;
  logic [31:0]    r_addr;
  logic           r_err;
  logic [31:0]    w_word;
  logic           w_legal;
  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [CW-1:0]  w_count;
  logic           w_start_ok;
  op_e            w_op;

  assign w_op       = op_e'(req_op);
  assign w_accept   = req_valid && req_ready;
  assign w_push     = w_accept && w_legal;
  assign w_pop      = im_we && im_ready;
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Encoder: fields not used by an op never reach the word.
  always_comb begin
    w_word  = '0;
    w_legal = 1'b1;
    case (w_op)
      OP_ADDU: w_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'h0, FN_ADDU};
      OP_SUBU: w_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'h0, FN_SUBU};
      OP_SLT:  w_word = {OPC_RTYPE, req_rs, req_rt, req_rd, 5'h0, FN_SLT};
      OP_ORI:  w_word = {OPC_ORI, req_rs, req_rt, req_imm};
      OP_LW:   w_word = {OPC_LW,  req_rs, req_rt, req_imm};
      OP_SW:   w_word = {OPC_SW,  req_rs, req_rt, req_imm};
      OP_LUI:  w_word = {OPC_LUI, 5'h0,   req_rt, req_imm};
      OP_LH:   w_word = {OPC_LH,  req_rs, req_rt, req_imm};
      OP_BEQ:  w_word = {OPC_BEQ, req_rs, req_rt, req_imm};
`ifdef ENC_JAL_JR_EN
      OP_JR:   w_word = {OPC_RTYPE, req_rs, 15'h0, FN_JR};
      OP_JAL:  w_word = {OPC_JAL, req_target};
`endif
      OP_NOP:  w_word = '0;
      default: w_legal = 1'b0;
    endcase
  end

`ifndef ENC_JAL_JR_EN
  // The jump target has no consumer when jal is not built.
  logic w_unused_target;
  assign w_unused_target = ^req_target;
`endif

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_wdata (w_word),
    .i_pop   (w_pop),
    .o_rdata (im_wdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign im_we   = !w_empty;
  assign im_addr = r_addr;
  assign err     = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        req_ready = !w_full;
        if (w_accept && req_last) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // An illegal last request can leave nothing to drain.
        if (w_empty || (w_pop && (w_count == CW'(1)))) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (w_start_ok) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= BASE_ADDR;
      r_err  <= 1'b0;
    end else begin
      if (w_start_ok)   r_addr <= BASE_ADDR;
      else if (w_pop)   r_addr <= r_addr + 32'd4;

      if (w_start_ok)                r_err <= 1'b0;
      else if (w_accept && !w_legal) r_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire
